// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared pipeline definitions for the fetch-redirect controller.
// Holds the fetch FSM states and the sequential PC stride.
package pc_redirect_ctrl_pkg;

    typedef enum logic {
        StRun,
        StSquash
    } fetch_state_e;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC register with branch redirect, wrong-path squash window and
// target sanity checking.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int unsigned PC_W     = 9,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned SQ_CYC   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Stall,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    output logic [PC_W-1:0] PC,
    output logic            PC_Valid,
    output logic            IF_ID_Flush,
    output logic            ID_EX_Flush,
    output logic            Target_Err,
    output logic [15:0]     Redirect_Cnt
);

    localparam int unsigned SQ_W = $clog2(SQ_CYC + 1);
    localparam logic [PC_W-1:0] RST_PC = RESET_PC[PC_W-1:0];

    fetch_state_e    r_state, w_state_d;
    logic [SQ_W-1:0] r_sq_cnt, w_sq_cnt_d;
    logic [PC_W-1:0] r_pc, w_pc_d;
    logic            r_err;
    logic            w_accept;
    logic            w_reject;
    logic [PC_W-1:0] w_pc_inc;

    // Target must be word aligned and fit inside the PC address space.
    assign w_accept = PcSel && (BrPC[1:0] == 2'b00) && ((BrPC >> PC_W) == 32'd0);
    assign w_reject = PcSel && !w_accept;
    assign w_pc_inc = r_pc + PC_W'(PC_INC);

    always_comb begin
        w_state_d   = r_state;
        w_sq_cnt_d  = r_sq_cnt;
        w_pc_d      = r_pc;
        PC_Valid    = (r_state == StRun);
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;

        if (w_accept) begin
            // The branch is older than whatever is stalled, so it wins.
            w_state_d   = StSquash;
            w_sq_cnt_d  = SQ_CYC[SQ_W-1:0];
            w_pc_d      = BrPC[PC_W-1:0];
            IF_ID_Flush = !reset;
            ID_EX_Flush = !reset;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (!Stall) begin
                        w_pc_d = w_pc_inc;
                    end
                end
                StSquash: begin
                    w_pc_d     = w_pc_inc;
                    w_sq_cnt_d = r_sq_cnt - 1'b1;
                    if (r_sq_cnt == SQ_W'(1)) begin
                        w_state_d = StRun;
                    end
                end
                default: begin
                    w_state_d = StRun;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StRun;
            r_sq_cnt <= '0;
            r_pc     <= RST_PC;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_sq_cnt <= w_sq_cnt_d;
            r_pc     <= w_pc_d;
            r_err    <= r_err | w_reject;
        end
    end

    sat_counter #(
        .W(16)
    ) u_redirect_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_accept),
        .o_cnt (Redirect_Cnt)
    );

    assign PC         = r_pc;
    assign Target_Err = r_err;

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are named clk and reset.
REQ-002 Parameter PC_W, default 9, SHALL set the PC width in bits.
REQ-003 Parameter RESET_PC, default 0, SHALL set the PC value loaded by reset.
REQ-004 Parameter SQ_CYC, default 1, range 1-3, SHALL set the number of wrong-path fetch slots squashed after a redirect (instruction memory read latency).
REQ-005 clk  in  1  pipeline clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 Stall  in  1  hazard-unit hold request: freeze PC and IF/ID.
REQ-008 PcSel  in  1  redirect request from the EX-stage branch unit.
REQ-009 BrPC  in  32  redirect target; sampled only when PcSel=1.
REQ-010 PC  out  PC_W  current fetch address, registered.
REQ-011 PC_Valid  out  1  the instruction presented to IF/ID this cycle is on the correct path.
REQ-012 IF_ID_Flush  out  1  squash the IF/ID register at the next edge.
REQ-013 ID_EX_Flush  out  1  squash the ID/EX register at the next edge.
REQ-014 Target_Err  out  1  sticky flag: a redirect target was rejected.
REQ-015 Redirect_Cnt  out  16  saturating count of accepted redirects.

Function
REQ-016 The FSM SHALL have two states, RUN and SQUASH, plus a squash counter sq_cnt of width ceil(log2(SQ_CYC+1)).
REQ-017 A redirect SHALL be accepted in a cycle when PcSel=1, BrPC[1:0]==0 and BrPC[31:PC_W]==0.
REQ-018 In RUN with no accepted redirect and Stall=0, PC SHALL advance to PC+4 modulo 2^PC_W (wrap-around, no error).
REQ-019 In RUN with no accepted redirect and Stall=1, PC SHALL hold its value.
REQ-020 In RUN, PC_Valid SHALL be 1.
REQ-021 In an acceptance cycle N, IF_ID_Flush and ID_EX_Flush SHALL both be 1 combinationally, in cycle N only.
REQ-022 An acceptance in cycle N SHALL load PC <= BrPC[PC_W-1:0] at the end of N, set state=SQUASH and set sq_cnt=SQ_CYC.
REQ-023 An accepted redirect SHALL override Stall in the same cycle, because the branch is older than the stalled instruction.
REQ-024 In SQUASH, PC_Valid SHALL be 0, PC SHALL advance by 4 each cycle and Stall SHALL be ignored.
REQ-025 In SQUASH, sq_cnt SHALL decrement each cycle, and the FSM SHALL return to RUN on the edge where sq_cnt goes 1->0.
REQ-026 A redirect accepted while in SQUASH SHALL be handled as in REQ-021/022: flushes asserted, PC reloaded, sq_cnt restarted at SQ_CYC.
REQ-027 A rejected redirect (PcSel=1 with a misaligned or out-of-range target) SHALL produce no flush and no PC load; PC behaves as if PcSel=0.
REQ-028 A rejected redirect SHALL set Target_Err=1 at the next edge; Target_Err then stays 1 until reset.
REQ-029 Redirect_Cnt SHALL increment by 1 per accepted redirect and saturate at 16'hFFFF.
REQ-030 When PcSel=0, BrPC SHALL be ignored.

Reset
REQ-031 On reset the block SHALL set PC=RESET_PC, state=RUN, sq_cnt=0, Target_Err=0 and Redirect_Cnt=0.
REQ-032 While reset=1, IF_ID_Flush and ID_EX_Flush SHALL be 0, and PC_Valid SHALL be 1 from the first cycle after reset.
REQ-033 Reset SHALL take priority over every input, including reset asserted in the middle of SQUASH; the pending squash is discarded.

Structure
REQ-034 The FSM state enum and the PC increment constant (4) SHALL live in the shared pipeline package.
REQ-035 The 16-bit saturating counter SHALL be a sub-module named sat_counter; the rest of the block is a single module.

Verification
REQ-036 Scenario: after reset, free run for 3 cycles -> PC sequence 0, 4, 8, 12 with PC_Valid=1 throughout.
REQ-037 Scenario: PC=0x010, PcSel=1, BrPC=0x40 -> both flushes=1 that cycle; next cycle PC=0x040, PC_Valid=0; the cycle after PC=0x044, PC_Valid=1; Redirect_Cnt=1.
REQ-038 Scenario: Stall=1 and PcSel=1 with BrPC=0x80 in the same cycle -> PC=0x080 next cycle (redirect wins); with Stall=1 alone, PC holds.
REQ-039 Scenario: PcSel=1 with BrPC=0x42 (misaligned) or BrPC=0x200 (out of range for PC_W=9) -> no flush, PC advances by 4, Target_Err=1 and remains 1.
REQ-040 Scenario: PC=0x1FC free-running -> PC=0x000 next cycle; redirect to 0x20 in the first SQUASH cycle with SQ_CYC=2 -> flushes reasserted, PC_Valid=0 for 2 more cycles.
REQ-041 Scenario: reset asserted during SQUASH -> next cycle PC=RESET_PC, PC_Valid=1, Redirect_Cnt=0.
